// File: rtl/ysyx_040066_mem_arbiter.sv
// N-channel round-robin arbiter that merges cache miss/refill/writeback
// channels onto one shared memory port. It locks the port for a whole
// transaction and counts burst beats. It also supervises the downstream side:
// a response timeout and a burst overrun are both reported to the owning
// channel through ch_err.
module ysyx_040066_mem_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCH-1:0]               ch_req,
    input  logic [NCH-1:0]               ch_wr,
    input  logic [NCH-1:0]               ch_burst,
    input  logic [NCH-1:0][2:0]          ch_len,
    input  logic [NCH-1:0][7:0]          ch_mask,
    input  logic [NCH-1:0][AW-1:0]       ch_addr,
    input  logic [NCH-1:0][LINE_W-1:0]   ch_wdata,
    output logic [NCH-1:0]               ch_ready,
    output logic                         ch_last,
    output logic                         ch_err,
    output logic [DW-1:0]                ch_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic                         mem_burst,
    output logic [2:0]                   mem_len,
    output logic [7:0]                   mem_mask,
    output logic [AW-1:0]                mem_addr,
    output logic [LINE_W-1:0]            mem_wdata,
    input  logic                         mem_ready,
    input  logic                         mem_err,
    input  logic                         mem_last,
    input  logic [DW-1:0]                mem_rdata,
    output logic [$clog2(NCH)-1:0]       grant_id,
    output logic                         busy
);

    localparam int BEATS = LINE_W / DW;
    localparam int GW    = $clog2(NCH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Request captured at grant time; the channel inputs are not looked at
    // again until the next arbitration.
    typedef struct packed {
        logic              wr;
        logic              burst;
        logic [2:0]        len;
        logic [7:0]        mask;
        logic [AW-1:0]     addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t         state, state_nxt;
    req_t           req_q;
    logic [GW-1:0]  rr_ptr;
    logic [BW-1:0]  beat_cnt;
    logic [WDW-1:0] wdog;

    logic           pick_vld;
    logic [GW-1:0]  pick_id;
    logic [GW:0]    cand;
    logic           timeout;
    logic           rsp_ok;
    logic           last_beat;
    logic           overrun;
    logic           xfer_end;
    logic           txn_end;

    // Round-robin search starting at rr_ptr. Walking the offsets downwards
    // lets the lowest offset with a request overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(i);
            if (cand >= (GW+1)'(NCH)) cand = cand - (GW+1)'(NCH);
            if (ch_req[cand[GW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[GW-1:0];
            end
        end
    end

    // Classify the current response. A timeout takes precedence, and any
    // mem_ready arriving in that cycle is dropped along with mem_req.
    always_comb begin
        timeout   = (TIMEOUT != 0) && (state == REQ) && (wdog == WDW'(TIMEOUT));
        rsp_ok    = (state == REQ) && !timeout && mem_ready;
        last_beat = (beat_cnt == BW'(BEATS - 1));
        overrun   = rsp_ok && !req_q.wr && req_q.burst && !mem_err
                    && !mem_last && last_beat;
        xfer_end  = rsp_ok && (mem_err || req_q.wr || !req_q.burst
                               || mem_last || last_beat);
        txn_end   = xfer_end || timeout;
    end

    // Responses go only to the owner. Nothing is routed outside REQ.
    always_comb begin
        ch_ready = '0;
        if (rsp_ok || timeout) ch_ready[grant_id] = 1'b1;
        ch_last  = txn_end;
        ch_err   = timeout || (rsp_ok && (mem_err || overrun));
        ch_rdata = rsp_ok ? mem_rdata : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. DONE is a fixed dead cycle so the owner can drop
    // ch_req before the next arbitration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = REQ;
            REQ:     if (txn_end)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, beat counter, watchdog and pointer rotation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            wdog     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick_id;
                        req_q    <= '{wr:    ch_wr[pick_id],
                                      burst: ch_burst[pick_id],
                                      len:   ch_len[pick_id],
                                      mask:  ch_mask[pick_id],
                                      addr:  ch_addr[pick_id],
                                      wdata: ch_wdata[pick_id]};
                    end
                end
                REQ: begin
                    if (rsp_ok) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        wdog     <= '0;
                    end else if (TIMEOUT != 0) begin
                        wdog     <= wdog + WDW'(1);
                    end
                end
                DONE: begin
                    rr_ptr   <= (grant_id == GW'(NCH - 1)) ? '0 : grant_id + GW'(1);
                    beat_cnt <= '0;
                    wdog     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == REQ) && !timeout;
    assign mem_wr    = req_q.wr;
    assign mem_burst = req_q.burst;
    assign mem_len   = req_q.len;
    assign mem_mask  = req_q.mask;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scenario bench for the memory arbiter. The bench plays the memory side. It
// queues the response each channel should see, and a negedge monitor pops and
// compares whenever any ch_ready is high.
module tb_ysyx_040066_mem_arbiter;
    localparam int NCH = 2, AW = 64, DW = 64, LINE_W = 512, TIMEOUT = 15;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NCH-1:0]             ch_req, ch_wr, ch_burst;
    logic [NCH-1:0][2:0]        ch_len;
    logic [NCH-1:0][7:0]        ch_mask;
    logic [NCH-1:0][AW-1:0]     ch_addr;
    logic [NCH-1:0][LINE_W-1:0] ch_wdata;
    logic [NCH-1:0]             ch_ready;
    logic                       ch_last, ch_err;
    logic [DW-1:0]              ch_rdata;
    logic                       mem_req, mem_wr, mem_burst;
    logic [2:0]                 mem_len;
    logic [7:0]                 mem_mask;
    logic [AW-1:0]              mem_addr;
    logic [LINE_W-1:0]          mem_wdata;
    logic                       mem_ready, mem_err, mem_last;
    logic [DW-1:0]              mem_rdata;
    logic [0:0]                 grant_id;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        logic [63:0] rdata;
        logic        last;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [NCH-1:0] mon_oh;

    ysyx_040066_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_burst(ch_burst), .ch_len(ch_len),
        .ch_mask(ch_mask), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_last(ch_last), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_burst(mem_burst), .mem_len(mem_len),
        .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_err(mem_err), .mem_last(mem_last), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Response monitor: every ch_ready pulse must match the head of the queue.
    always @(negedge clk) begin
        if (ch_ready !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: ch_ready=%b rdata=%h", ch_ready, ch_rdata);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_oh = NCH'(1) << mon_e.ch;
                if (ch_ready !== mon_oh || ch_rdata !== mon_e.rdata ||
                    ch_last !== mon_e.last || ch_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp: got ready=%b rdata=%h last=%b err=%b, want ready=%b rdata=%h last=%b err=%b",
                             ch_ready, ch_rdata, ch_last, ch_err, mon_oh, mon_e.rdata, mon_e.last, mon_e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (mem_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic respond(input int ch, input logic [63:0] d, input logic last, input logic err,
                           input logic exp_last, input logic exp_err);
        exp_q.push_back('{ch, d, exp_last, exp_err});
        mem_ready = 1'b1; mem_rdata = d; mem_last = last; mem_err = err;
        step();
        mem_ready = 1'b0; mem_rdata = '0; mem_last = 1'b0; mem_err = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 || ch_ready !== '0 ||
            ch_last !== 1'b0 || ch_err !== 1'b0 || ch_rdata !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: mem_req=%b busy=%b gid=%b rdy=%b last=%b err=%b rdata=%h, want all 0",
                     mem_req, busy, grant_id, ch_ready, ch_last, ch_err, ch_rdata);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_wr !== 1'b0 || mem_burst !== 1'b0 ||
            mem_len !== '0 || mem_mask !== '0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h wr=%b burst=%b len=%h mask=%h, want 0", mem_addr, mem_wr, mem_burst, mem_len, mem_mask);
        end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_contention();
        int n;
        ch_addr[0] = 64'h1000; ch_addr[1] = 64'h2000;
        ch_wr = '0; ch_burst = '0; ch_len[0] = 3'd3; ch_len[1] = 3'd3;
        ch_req = 2'b11;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL cont_early: mem_req=%b want 0", mem_req); end
        wait_req(n);
        checks++;
        if (n != 1 || mem_addr !== 64'h1000 || grant_id !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_grant0: lat=%0d addr=%h gid=%b busy=%b, want 1 1000 0 1", n, mem_addr, grant_id, busy);
        end
        respond(0, 64'hA0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_req(n);
        checks++;
        if (n != 2 || mem_addr !== 64'h2000 || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL cont_grant1: gap=%0d addr=%h gid=%b, want 2 2000 1", n, mem_addr, grant_id);
        end
        ch_req = 2'b01;
        respond(1, 64'hA1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_req(n);
        checks++;
        if (n != 2 || mem_addr !== 64'h1000 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL cont_regrant0: gap=%0d addr=%h gid=%b, want 2 1000 0", n, mem_addr, grant_id);
        end
        ch_req = 2'b00;
        // single read ends on first mem_ready even without mem_last
        respond(0, 64'hA2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(); step();
    endtask

    task automatic test_burst_read();
        int n;
        ch_addr[1] = 64'h3040; ch_burst[1] = 1'b1; ch_wr[1] = 1'b0;
        ch_req = 2'b10;
        wait_req(n);
        checks++;
        if (n != 1 || grant_id !== 1'b1 || mem_burst !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 64'h3040) begin
            errors++;
            $display("FAIL burst_grant: lat=%0d gid=%b burst=%b wr=%b addr=%h", n, grant_id, mem_burst, mem_wr, mem_addr);
        end
        for (int k = 1; k <= 8; k++) begin
            respond(1, 64'(k * 17), k == 8, 1'b0, k == 8, 1'b0);
            if (k == 2) ch_req = 2'b00;
            if (k == 3) begin
                step(); step();
                checks++;
                if (mem_req !== 1'b1) begin errors++; $display("FAIL burst_hold: mem_req=%b want 1", mem_req); end
            end
        end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL burst_end: mem_req=%b want 0", mem_req); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing: %0d beats not seen, want 0", exp_q.size()); end
        step(); step();
    endtask

    task automatic test_overrun();
        int n;
        ch_addr[0] = 64'h5000; ch_burst = 2'b01; ch_wr = '0;
        ch_req = 2'b01;
        wait_req(n);
        ch_req = 2'b00;
        checks++;
        if (n != 1 || grant_id !== 1'b0) begin errors++; $display("FAIL ovr_grant: lat=%0d gid=%b, want 1 0", n, grant_id); end
        for (int k = 1; k <= 8; k++) respond(0, 64'(k * 3), 1'b0, 1'b0, k == 8, k == 8);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL ovr_end: mem_req=%b want 0", mem_req); end
        step(); step();
    endtask

    task automatic test_timeout();
        int n, cnt;
        ch_addr[1] = 64'h6000; ch_burst = '0; ch_wr = '0;
        ch_req = 2'b10;
        wait_req(n);
        ch_req = 2'b00;
        exp_q.push_back('{1, 64'h0, 1'b1, 1'b1});
        cnt = 1;
        while (mem_req === 1'b1 && cnt < 64) begin
            step();
            if (mem_req === 1'b1) cnt++;
        end
        checks++;
        if (cnt != TIMEOUT) begin errors++; $display("FAIL tmo_len: mem_req cycles=%0d want %0d", cnt, TIMEOUT); end
        checks++;
        if (ch_ready !== 2'b10 || ch_err !== 1'b1 || ch_last !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: rdy=%b err=%b last=%b, want 10 1 1", ch_ready, ch_err, ch_last);
        end
        step();
        checks++;
        if (mem_req !== 1'b0 || ch_ready !== '0) begin
            errors++;
            $display("FAIL tmo_after: mem_req=%b rdy=%b, want 0 00", mem_req, ch_ready);
        end
        step();
    endtask

    task automatic test_write_line();
        int n;
        logic [LINE_W-1:0] wd;
        for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'h0123_4567_89ab_cdef + 64'(k) * 64'h1111_1111_1111_1111;
        ch_addr[0] = 64'h7000_0040; ch_wdata[0] = wd; ch_mask[0] = 8'hFF; ch_len[0] = 3'd6;
        ch_wr = 2'b01; ch_burst = 2'b01;
        ch_req = 2'b01;
        wait_req(n);
        // scramble the inputs: the port must keep the latched request
        ch_wdata[0] = ~wd; ch_addr[0] = '0; ch_mask[0] = '0; ch_len[0] = '0; ch_wr = '0; ch_req = '0;
        #1;
        checks++;
        if (n != 1 || mem_wr !== 1'b1 || mem_burst !== 1'b1 || mem_addr !== 64'h7000_0040 ||
            mem_mask !== 8'hFF || mem_len !== 3'd6) begin
            errors++;
            $display("FAIL wr_ctrl: lat=%0d wr=%b burst=%b addr=%h mask=%h len=%0d", n, mem_wr, mem_burst, mem_addr, mem_mask, mem_len);
        end
        checks++;
        if (mem_wdata !== wd) begin errors++; $display("FAIL wr_data: got %h want %h", mem_wdata[63:0], wd[63:0]); end
        respond(0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_end: mem_req=%b want 0", mem_req); end
        step(); step();
    endtask

    task automatic test_back_to_back();
        int n;
        ch_addr[0] = 64'h8000; ch_addr[1] = 64'h9000;
        ch_wr = '0; ch_burst = 2'b10;
        ch_req = 2'b11;
        wait_req(n);
        checks++;
        if (n != 1 || grant_id !== 1'b1 || mem_addr !== 64'h9000) begin
            errors++;
            $display("FAIL b2b_rr: lat=%0d gid=%b addr=%h, want 1 1 9000", n, grant_id, mem_addr);
        end
        ch_req = 2'b01;
        respond(1, 64'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        respond(1, 64'h66, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_req(n);
        checks++;
        if (n != 2 || grant_id !== 1'b0 || mem_addr !== 64'h8000) begin
            errors++;
            $display("FAIL b2b_next: gap=%0d gid=%b addr=%h, want 2 0 8000", n, grant_id, mem_addr);
        end
        ch_req = 2'b00;
        respond(0, 64'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); step();
    endtask

    task automatic test_idle_ignore();
        mem_ready = 1'b1; mem_rdata = 64'hBAD; mem_last = 1'b1;
        #1;
        checks++;
        if (ch_ready !== '0 || ch_last !== 1'b0 || ch_rdata !== '0) begin
            errors++;
            $display("FAIL idle_route: rdy=%b last=%b rdata=%h, want 0", ch_ready, ch_last, ch_rdata);
        end
        step();
        mem_ready = 1'b0; mem_rdata = '0; mem_last = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_state: mem_req=%b busy=%b, want 0 0", mem_req, busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        ch_addr[0] = 64'hA000; ch_burst = 2'b01; ch_wr = '0;
        ch_req = 2'b01;
        wait_req(n);
        for (int k = 1; k <= 3; k++) respond(0, 64'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_pre: mem_req=%b want 1", mem_req); end
        mem_ready = 1'b1; mem_rdata = 64'h44;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ch_ready !== '0 || busy !== 1'b0 || grant_id !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rmid_async: mem_req=%b rdy=%b busy=%b gid=%b addr=%h, want 0", mem_req, ch_ready, busy, grant_id, mem_addr);
        end
        mem_ready = 1'b0; mem_rdata = '0; ch_req = '0; ch_burst = '0;
        step(); step();
        rst = 1'b1;
        step();
        ch_addr[1] = 64'hB000;
        ch_req = 2'b11;
        wait_req(n);
        checks++;
        if (n != 1 || grant_id !== 1'b0 || mem_addr !== 64'hA000) begin
            errors++;
            $display("FAIL rmid_rr: lat=%0d gid=%b addr=%h, want 1 0 A000", n, grant_id, mem_addr);
        end
        ch_req = 2'b10;
        respond(0, 64'h99, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_req(n);
        checks++;
        if (n != 2 || grant_id !== 1'b1) begin errors++; $display("FAIL rmid_ch1: gap=%0d gid=%b, want 2 1", n, grant_id); end
        ch_req = 2'b00;
        respond(1, 64'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); step();
    endtask

    initial begin
        rst = 1'b0;
        ch_req = '0; ch_wr = '0; ch_burst = '0; ch_len = '0; ch_mask = '0;
        ch_addr = '0; ch_wdata = '0;
        mem_ready = 1'b0; mem_err = 1'b0; mem_last = 1'b0; mem_rdata = '0;
        test_reset();
        test_contention();
        test_burst_read();
        test_overrun();
        test_timeout();
        test_write_line();
        test_back_to_back();
        test_idle_ignore();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending: %0d responses never seen, want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/ysyx_040066_mem_arbiter.md
Name: ysyx_040066_mem_arbiter

Overview:
- Parametrised N-channel arbiter that merges independent cache-side miss/refill/writeback request channels onto one shared memory request port.
- Typical users: I-cache, D-cache, later an MMU walker.
- Round-robin grant with per-transaction lock and burst beat counting.
- Protocol supervision the per-cache ports lack: a response-timeout watchdog and a burst-overrun check, both reported as a per-channel error.

Parameters:
- NCH, 2, number of requesting channels (≥2).
- AW, 64, address width.
- DW, 64, read beat width.
- LINE_W, 512, write-line width; BEATS = LINE_W/DW.
- TIMEOUT, 1023, max cycles waiting for mem_ready before forced error; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ch_req  in  NCH  per-channel request, held until the channel's final ch_ready
- ch_wr  in  NCH  1 = write line, 0 = read
- ch_burst  in  NCH  1 = line burst (BEATS beats / full line), 0 = single beat
- ch_len  in  NCH*3  access size code, passed through
- ch_mask  in  NCH*8  byte mask for single writes
- ch_addr  in  NCH*AW  request address
- ch_wdata  in  NCH*LINE_W  write data; single writes use bits [DW-1:0]
- ch_ready  out  NCH  response strobe, granted channel only
- ch_last  out  1  final beat/response of transaction
- ch_err  out  1  error qualifier, valid with ch_ready
- ch_rdata  out  DW  read beat data
- mem_req, mem_wr, mem_burst  out  1 each  downstream request
- mem_len  out  3  downstream size code
- mem_mask  out  8  downstream byte mask
- mem_addr  out  AW  downstream address
- mem_wdata  out  LINE_W  downstream write data
- mem_ready, mem_err, mem_last  in  1 each  downstream response
- mem_rdata  in  DW  downstream read data
- grant_id  out  clog2(NCH)  index of current owner (debug)
- busy  out  1  transaction in progress

Behaviour:
- Reset (rst low, async): FSM=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0; wdog=0.
  - All mem_* outputs, ch_ready, ch_last, ch_err, ch_rdata, and busy are 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Select the first channel with ch_req=1, searching rr_ptr, rr_ptr+1, … mod NCH.
  - Latch its wr/burst/len/mask/addr/wdata into request registers; set grant_id; go to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req=1; mem_* driven from the latched registers, so later channel input changes are ignored; busy=1.
  - mem_ready/mem_err/mem_last/mem_rdata are routed combinationally to the granted channel: ch_ready[grant_id]=mem_ready, all other ch_ready bits are 0.
  - ch_last is asserted with the final response.
  - Read burst: beat_cnt increments per mem_ready. Transaction ends on mem_ready&&mem_last.
  - Burst overrun: if mem_ready arrives with beat_cnt==BEATS-1 and mem_last=0, end the transaction with ch_err=1 and ch_last=1 forced on that beat.
  - Write, or single read: ends on the first mem_ready.
  - Early end: mem_ready&&mem_err ends the transaction immediately with ch_last=1.
  - Watchdog: wdog counts cycles without mem_ready and clears on each mem_ready. If wdog reaches TIMEOUT (TIMEOUT≠0), the arbiter drops mem_req and pulses ch_ready=1, ch_err=1, ch_last=1 for one cycle to the owner.
  - On any end: go to DONE.
- DONE:
  - One dead cycle; mem_req=0; rr_ptr=(grant_id+1) mod NCH; beat_cnt=0; wdog=0; go to IDLE.
  - Guarantees a requester sees ch_req→ch_ready no earlier than 2 cycles and lets the channel drop ch_req before re-arbitration.
- Latency: ch_req sampled in cycle t → mem_req asserted in t+1.
- Back-to-back same channel: the next grant occurs no earlier than t_end+2. The rotated rr_ptr gives other pending channels priority.
- Requester dropping ch_req during REQ: the transaction still completes downstream and responses are still presented on ch_ready (the channel must ignore them).
- Simultaneous requests: exactly one grant per arbitration; no channel is starved beyond NCH-1 transactions.
- mem_ready while not in REQ is ignored; it is never routed.

Test Plan:
- Reset mid-transaction: NCH=2, ch0 read burst in REQ at beat 3, assert rst=0 → same cycle mem_req=0, ch_ready=0; after release grant_id=0, rr_ptr=0, FSM IDLE.
- Contention: ch0, ch1 both request reads at t=0 → ch0 granted (mem_req at t=1, addr=ch0). After its last beat plus the DONE cycle, ch1 is granted; a re-request by ch0 waits until ch1 completes.
- Burst read: ch1 burst, mem returns 8 beats 0x11..0x88 with mem_last on the 8th → ch_ready[1] pulses 8 times with matching ch_rdata, ch_last only on beat 8, ch_ready[0] stays 0.
- Overrun: mem returns 8 beats with no mem_last → beat 8 shows ch_err=1 and ch_last=1; mem_req=0 in the next cycle.
- Timeout: TIMEOUT=15, mem_ready never asserts → mem_req drops after 15 cycles in REQ with a one-cycle ch_ready/ch_err/ch_last pulse.
- Write line: ch0 write, wdata=512'h0123…, mask=8'hFF → mem_wr=1, mem_burst=1, mem_wdata is bit-exact; a single mem_ready completes the transaction and rr_ptr becomes 1.
